// File: rtl/bat_mem_unit.sv
// Memory stage for the BatAmateur controller: MAR plus word-addressed RAM, with a halted-CPU loader port.
// Optional CPU write protection of the low vector area is built when BAT_MEM_WPROT_EN is defined.
module bat_mem_unit #(
    parameter int unsigned AW = 8,
`ifdef BAT_MEM_WPROT_EN
    parameter int unsigned PROT_TOP = 'h0F,
`endif
    parameter int unsigned DW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          HALT,
    input  logic [1:0]    MAR_CTL,
    input  logic [1:0]    RAM_CTL,
    input  logic [DW-1:0] BUS_IN,
    output logic [DW-1:0] BUS_OUT,
    output logic          BUS_DRV,
    input  logic          EXT_REQ,
    input  logic          EXT_RW,
    input  logic [AW-1:0] EXT_ADDR,
    input  logic [DW-1:0] EXT_WDATA,
    output logic [DW-1:0] EXT_RDATA,
    output logic          EXT_ACK,
    output logic [DW-1:0] MAR_Q,
    output logic          WP_ERR
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StAccess, StAck, StWaitDrop} ext_state_e;

    ext_state_e    state_q, state_d;
    logic [DW-1:0] mem [Depth];
    logic [DW-1:0] mar_q;
    logic [DW-1:0] ext_rdata_q;
    logic [AW-1:0] mar_addr;

    logic cpu_en, cpu_rd, cpu_wr_req, cpu_wr, mar_ld, ext_wr, ext_rd;

    assign mar_addr  = mar_q[AW-1:0];
    assign MAR_Q     = mar_q;
    assign EXT_RDATA = ext_rdata_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (EXT_REQ && HALT) state_d = StAccess;
            StAccess:   state_d = StAck;
            StAck:      state_d = StWaitDrop;
            StWaitDrop: if (!EXT_REQ) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // CPU owns the RAM only when running and no loader access is in flight.
    always_comb begin
        cpu_en     = !HALT && (state_q == StIdle || state_q == StWaitDrop);
        cpu_rd     = cpu_en && (RAM_CTL == 2'b11);
        cpu_wr_req = cpu_en && (RAM_CTL == 2'b01);
        mar_ld     = cpu_en && (MAR_CTL == 2'b01);
        ext_wr     = (state_q == StAccess) && !EXT_RW;
        ext_rd     = (state_q == StAccess) && EXT_RW;
        EXT_ACK    = (state_q == StAck);
        BUS_DRV    = cpu_rd;
        BUS_OUT    = '0;
        if (cpu_rd) BUS_OUT = mem[mar_addr];
    end

`ifdef BAT_MEM_WPROT_EN
    logic wp_hit, wp_err_q;

    assign wp_hit = mar_addr <= PROT_TOP[AW-1:0];
    assign cpu_wr = cpu_wr_req && !wp_hit;
    assign WP_ERR = wp_err_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wp_err_q <= 1'b0;
        end else if (cpu_wr_req && wp_hit) begin
            wp_err_q <= 1'b1;
        end
    end
`else
    assign cpu_wr = cpu_wr_req;
    assign WP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            mar_q <= '0;
        end else if (mar_ld) begin
            mar_q <= BUS_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ext_rdata_q <= '0;
        end else if (ext_rd) begin
            ext_rdata_q <= mem[EXT_ADDR];
        end
    end

    // RAM is not reset; a reset edge suppresses any pending write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (cpu_wr) begin
                mem[mar_addr] <= BUS_IN;
            end else if (ext_wr) begin
                mem[EXT_ADDR] <= EXT_WDATA;
            end
        end
    end

endmodule

// File: tb/tb_bat_mem_unit.sv
// Self-checking bench for bat_mem_unit: vector table for CPU accesses, scoreboard for read data,
// hand-written sequences for loader handshake, overlap, protection and reset corner cases.
module tb_bat_mem_unit;

    logic        clk = 1'b0;
    logic        rst, halt;
    logic [1:0]  mar_ctl, ram_ctl;
    logic [15:0] bus_in, bus_out, ext_wdata, ext_rdata, mar_q;
    logic        bus_drv, ext_req, ext_rw, ext_ack, wp_err;
    logic [7:0]  ext_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sb_q[$];
    logic [15:0] model [256];

`ifdef BAT_MEM_WPROT_EN
    localparam logic ExpWp = 1'b1;
`else
    localparam logic ExpWp = 1'b0;
`endif

    typedef struct {
        logic [15:0] mar;
        logic [15:0] wdata;
        logic [15:0] rd_mar;
        logic [15:0] exp_rd;
    } cpu_vec_t;

    bat_mem_unit dut (
        .CLK       (clk),
        .RST       (rst),
        .HALT      (halt),
        .MAR_CTL   (mar_ctl),
        .RAM_CTL   (ram_ctl),
        .BUS_IN    (bus_in),
        .BUS_OUT   (bus_out),
        .BUS_DRV   (bus_drv),
        .EXT_REQ   (ext_req),
        .EXT_RW    (ext_rw),
        .EXT_ADDR  (ext_addr),
        .EXT_WDATA (ext_wdata),
        .EXT_RDATA (ext_rdata),
        .EXT_ACK   (ext_ack),
        .MAR_Q     (mar_q),
        .WP_ERR    (wp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sb_chk(input string name, input logic [15:0] got);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %h expected <scoreboard empty>", name, got);
        end else begin
            chk(name, {16'h0, got}, {16'h0, sb_q.pop_front()});
        end
    endtask

    task automatic ext_access(input logic rw, input logic [7:0] addr, input logic [15:0] wd);
        int lat = 0;
        ext_req = 1'b1; ext_rw = rw; ext_addr = addr; ext_wdata = wd;
        if (rw) sb_q.push_back(model[addr]);
        else    model[addr] = wd;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ext_ack) begin
                lat = i;
                break;
            end
        end
        chk("ext_latency", lat, 2);
        if (rw) begin
            if (lat != 0) sb_chk("ext_rdata", ext_rdata);
            else if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        ext_req = 1'b0;
        tick();
        chk("ext_ack_one_cycle", {31'h0, ext_ack}, 0);
        tick();
    endtask

    cpu_vec_t vecs[5];

    initial begin
        int acks;
        int found;

        vecs[0] = '{mar: 16'h0020, wdata: 16'hBEEF, rd_mar: 16'h0020, exp_rd: 16'hBEEF};
        vecs[1] = '{mar: 16'h0125, wdata: 16'h1357, rd_mar: 16'h0025, exp_rd: 16'h1357};
        vecs[2] = '{mar: 16'hFF40, wdata: 16'h2468, rd_mar: 16'h0140, exp_rd: 16'h2468};
        vecs[3] = '{mar: 16'h00FF, wdata: 16'hA5A5, rd_mar: 16'h01FF, exp_rd: 16'hA5A5};
        vecs[4] = '{mar: 16'h0021, wdata: 16'h0F0F, rd_mar: 16'h0020, exp_rd: 16'hBEEF};

        rst = 1'b0; halt = 1'b0; mar_ctl = 2'b01; ram_ctl = 2'b00; bus_in = 16'h1234;
        ext_req = 1'b0; ext_rw = 1'b0; ext_addr = '0; ext_wdata = '0;
        tick();
        tick();
        chk("rst_mar", {16'h0, mar_q}, 0);
        chk("rst_bus_drv", {31'h0, bus_drv}, 0);
        chk("rst_bus_out", {16'h0, bus_out}, 0);
        chk("rst_ext_ack", {31'h0, ext_ack}, 0);
        chk("rst_ext_rdata", {16'h0, ext_rdata}, 0);
        chk("rst_wp_err", {31'h0, wp_err}, 0);
        rst = 1'b1; mar_ctl = 2'b00;
        tick();

        foreach (vecs[k]) begin
            mar_ctl = 2'b01; ram_ctl = 2'b00; bus_in = vecs[k].mar;
            tick();
            chk("mar_load", {16'h0, mar_q}, {16'h0, vecs[k].mar});
            mar_ctl = 2'b00; ram_ctl = 2'b01; bus_in = vecs[k].wdata;
            model[vecs[k].mar[7:0]] = vecs[k].wdata;
            tick();
            mar_ctl = 2'b01; ram_ctl = 2'b00; bus_in = vecs[k].rd_mar;
            tick();
            mar_ctl = 2'b00; ram_ctl = 2'b11;
            sb_q.push_back(vecs[k].exp_rd);
            #1;
            chk("cpu_rd_drv", {31'h0, bus_drv}, 1);
            sb_chk("cpu_rd_data", bus_out);
        end

        // Same-cycle MAR load and read: old address read, new one next cycle.
        mar_ctl = 2'b01; ram_ctl = 2'b00; bus_in = 16'h0040;
        tick();
        mar_ctl = 2'b01; ram_ctl = 2'b11; bus_in = 16'h0320;
        sb_q.push_back(16'h2468);
        #1;
        sb_chk("overlap_old_mar", bus_out);
        tick();
        mar_ctl = 2'b00;
        chk("overlap_new_mar", {16'h0, mar_q}, 32'h0320);
        sb_q.push_back(16'hBEEF);
        #1;
        sb_chk("overlap_wrap_read", bus_out);
        ram_ctl = 2'b10;
        #1;
        chk("idle_bus_drv", {31'h0, bus_drv}, 0);
        chk("idle_bus_out", {16'h0, bus_out}, 0);

        // CPU controls are ignored while halted.
        halt = 1'b1; mar_ctl = 2'b01; ram_ctl = 2'b01; bus_in = 16'h0077;
        tick();
        chk("halt_mar_hold", {16'h0, mar_q}, 32'h0320);
        mar_ctl = 2'b00; ram_ctl = 2'b11;
        #1;
        chk("halt_bus_drv", {31'h0, bus_drv}, 0);
        ram_ctl = 2'b00;
        tick();

        ext_access(1'b0, 8'h00, 16'h7F81);
        ext_access(1'b0, 8'h01, 16'h4005);
        ext_access(1'b0, 8'h02, 16'h0000);
        ext_access(1'b0, 8'h03, 16'hFFFF);
        for (int a = 0; a < 4; a++) ext_access(1'b1, 8'(a), 16'h0);
        ext_access(1'b1, 8'h20, 16'h0);

        // Request while running stays pending, then exactly one ACK after HALT rises.
        halt = 1'b0; ext_req = 1'b1; ext_rw = 1'b1; ext_addr = 8'h01;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ext_ack) acks++;
        end
        chk("no_ack_running", acks, 0);
        halt = 1'b1;
        sb_q.push_back(model[1]);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ext_ack) begin
                found = 1;
                sb_chk("pending_rdata", ext_rdata);
                break;
            end
        end
        if (found == 0 && sb_q.size() > 0) void'(sb_q.pop_front());
        chk("ack_after_halt", found, 1);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ext_ack) acks++;
        end
        chk("no_double_ack", acks, 0);
        ext_req = 1'b0;
        tick();
        tick();

        // CPU write into the vector area; loader writes are never blocked.
        ext_access(1'b0, 8'h05, 16'h1111);
        halt = 1'b0; mar_ctl = 2'b01; bus_in = 16'h0005;
        tick();
        mar_ctl = 2'b00; ram_ctl = 2'b01; bus_in = 16'hAAAA;
        if (!ExpWp) model[5] = 16'hAAAA;
        tick();
        ram_ctl = 2'b11;
        sb_q.push_back(model[5]);
        #1;
        sb_chk("prot_cpu_write", bus_out);
        chk("wp_err", {31'h0, wp_err}, {31'h0, ExpWp});
        ram_ctl = 2'b00; halt = 1'b1;
        tick();
        ext_access(1'b0, 8'h05, 16'h2222);
        ext_access(1'b1, 8'h05, 16'h0);
        chk("wp_err_sticky", {31'h0, wp_err}, {31'h0, ExpWp});

        // Reset landing on the ACCESS edge drops the write and the ACK.
        ext_access(1'b0, 8'h10, 16'h5555);
        ext_req = 1'b1; ext_rw = 1'b0; ext_addr = 8'h10; ext_wdata = 16'h9999;
        tick();
        rst = 1'b0; ext_req = 1'b0;
        tick();
        chk("rst_access_ack", {31'h0, ext_ack}, 0);
        chk("rst_access_mar", {16'h0, mar_q}, 0);
        chk("rst_access_wp", {31'h0, wp_err}, 0);
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ext_ack) acks++;
        end
        chk("rst_access_no_ack", acks, 0);
        ext_access(1'b1, 8'h10, 16'h0);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
